hero_mover: RTL and testbench

//  Parametrised hero movement controller for the playfield. Runs on a single clock;

---
 rtl/hero_pkg.sv | 17 +
 rtl/aabb_overlap.sv | 38 +++
 rtl/hero_mover.sv | 213 +++++++++++++++++++++
 tb/tb_hero_mover.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hero_pkg.sv
// Shared types and encodings for the hero movement controller.
package hero_pkg;

  localparam int HERO_W = 12;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MOVE   = 2'd1,
    S_ATTACK = 2'd2
  } state_e;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_RIGHT = 2'd2;
  localparam logic [1:0] DIR_DOWN  = 2'd3;

endpackage

// File: rtl/aabb_overlap.sv
// Combinational overlap test between two equal-sized squares given by their
// top-left corners. Strict mode lets faces touch; inclusive mode counts a
// shared face as a hit. Sums are one bit wider so corner+SIDE never wraps.
module aabb_overlap
  import hero_pkg::*;
#(
  parameter int W         = HERO_W,
  parameter int SIDE      = 60,
  parameter bit INCLUSIVE = 1'b0
) (
  input  logic [W-1:0] ax_i,
  input  logic [W-1:0] ay_i,
  input  logic [W-1:0] bx_i,
  input  logic [W-1:0] by_i,
  output logic         hit_o
);

  localparam logic [W:0] SIDE_E = (W+1)'(SIDE);

  logic [W:0] axLo, axHi, ayLo, ayHi, bxLo, bxHi, byLo, byHi;

  assign axLo = {1'b0, ax_i};
  assign ayLo = {1'b0, ay_i};
  assign bxLo = {1'b0, bx_i};
  assign byLo = {1'b0, by_i};
  assign axHi = axLo + SIDE_E;
  assign ayHi = ayLo + SIDE_E;
  assign bxHi = bxLo + SIDE_E;
  assign byHi = byLo + SIDE_E;

  // Pick the comparison flavour once at elaboration time.
  if (INCLUSIVE) begin : g_incl
    assign hit_o = (axLo <= bxHi) && (axHi >= bxLo) && (ayLo <= byHi) && (ayHi >= byLo);
  end else begin : g_strict
    assign hit_o = (axLo < bxHi) && (axHi > bxLo) && (ayLo < byHi) && (ayHi > byLo);
  end

endmodule

// File: rtl/hero_mover.sv
// Hero movement controller: tick-paced single-axis moves with arena clamping
// and obstacle rejection, a tick-timed attack window, and per-block contact
// flags that stay up for a while after the hero stops touching a block.
module hero_mover
  import hero_pkg::*;
#(
  parameter int W          = HERO_W,
  parameter int NUM_BLOCKS = 4,
  parameter int SIDE       = 60,
  parameter int STEP       = 1,
  parameter int X_MIN      = 62,
  parameter int X_MAX      = 962,
  parameter int Y_MIN      = 108,
  parameter int Y_MAX      = 708,
  parameter int X_INIT     = 512,
  parameter int Y_INIT     = 300,
  parameter int ATTACK_LEN = 8,
  parameter int HOLD_TIME  = 200
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    move_tick_i,
  input  logic                    up_i,
  input  logic                    left_i,
  input  logic                    right_i,
  input  logic                    down_i,
  input  logic                    center_i,
  input  logic [NUM_BLOCKS*W-1:0] block_x_i,
  input  logic [NUM_BLOCKS*W-1:0] block_y_i,
  input  logic [NUM_BLOCKS-1:0]   block_en_i,
  output logic [W-1:0]            x_pos_o,
  output logic [W-1:0]            y_pos_o,
  output logic [1:0]              dir_o,
  output logic                    attack_o,
  output logic                    blocked_o,
  output logic [NUM_BLOCKS-1:0]   contact_o
);

  localparam int TW = (ATTACK_LEN > 1) ? $clog2(ATTACK_LEN) : 1;
  localparam int HW = (HOLD_TIME > 1) ? $clog2(HOLD_TIME) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(ATTACK_LEN - 1);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_TIME - 1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

  localparam logic [W:0]   STEP_E = (W+1)'(STEP);
  localparam logic [W:0]   XMIN_E = (W+1)'(X_MIN);
  localparam logic [W:0]   XMAX_E = (W+1)'(X_MAX);
  localparam logic [W:0]   YMIN_E = (W+1)'(Y_MIN);
  localparam logic [W:0]   YMAX_E = (W+1)'(Y_MAX);
  localparam logic [W-1:0] XINIT  = W'(X_INIT);
  localparam logic [W-1:0] YINIT  = W'(Y_INIT);

  state_e          state_q, state_d;
  logic [W-1:0]    x_q, x_d, y_q, y_d;
  logic [1:0]      dir_q, dir_d;
  logic            attack_q, attack_d;
  logic            blocked_q, blocked_d;
  logic [TW-1:0]   tickCnt_q, tickCnt_d;
  logic [HW-1:0]   holdCnt_q [NUM_BLOCKS];
  logic [NUM_BLOCKS-1:0] contact_q;

  logic [W:0]      xExt, yExt;
  logic [W-1:0]    candX, candY;
  logic [NUM_BLOCKS-1:0] strictHit, touchHit, touch;
  logic            anyHit, moveIsNop;

  assign xExt = {1'b0, x_q};
  assign yExt = {1'b0, y_q};

  // One-axis candidate in the latched facing direction, clamped to the arena
  // without ever wrapping below the minimum.
  always_comb begin
    candX = x_q;
    candY = y_q;
    case (dir_q)
      DIR_UP:    candY = (yExt < YMIN_E + STEP_E) ? YMIN_E[W-1:0] : y_q - STEP_E[W-1:0];
      DIR_LEFT:  candX = (xExt < XMIN_E + STEP_E) ? XMIN_E[W-1:0] : x_q - STEP_E[W-1:0];
      DIR_RIGHT: candX = (xExt + STEP_E > XMAX_E) ? XMAX_E[W-1:0] : x_q + STEP_E[W-1:0];
      default:   candY = (yExt + STEP_E > YMAX_E) ? YMAX_E[W-1:0] : y_q + STEP_E[W-1:0];
    endcase
  end

  for (genvar i = 0; i < NUM_BLOCKS; i++) begin : g_blk
    aabb_overlap #(.W(W), .SIDE(SIDE), .INCLUSIVE(1'b0)) u_strict (
      .ax_i (candX),
      .ay_i (candY),
      .bx_i (block_x_i[i*W +: W]),
      .by_i (block_y_i[i*W +: W]),
      .hit_o(strictHit[i])
    );
    aabb_overlap #(.W(W), .SIDE(SIDE), .INCLUSIVE(1'b1)) u_touch (
      .ax_i (x_q),
      .ay_i (y_q),
      .bx_i (block_x_i[i*W +: W]),
      .by_i (block_y_i[i*W +: W]),
      .hit_o(touchHit[i])
    );
  end

  assign anyHit    = |(strictHit & block_en_i);
  assign touch     = touchHit & block_en_i;
  assign moveIsNop = (candX == x_q) && (candY == y_q);

  // Next-state logic: button sampling in IDLE, commit/reject in MOVE,
  // tick counting in ATTACK.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    dir_d     = dir_q;
    attack_d  = attack_q;
    blocked_d = 1'b0;
    tickCnt_d = tickCnt_q;
    case (state_q)
      S_IDLE: begin
        if (move_tick_i) begin
          if (up_i) begin
            dir_d   = DIR_UP;
            state_d = S_MOVE;
          end else if (left_i) begin
            dir_d   = DIR_LEFT;
            state_d = S_MOVE;
          end else if (right_i) begin
            dir_d   = DIR_RIGHT;
            state_d = S_MOVE;
          end else if (down_i) begin
            dir_d   = DIR_DOWN;
            state_d = S_MOVE;
          end else if (center_i) begin
            attack_d  = 1'b1;
            tickCnt_d = '0;
            state_d   = S_ATTACK;
          end
        end
      end
      S_MOVE: begin
        state_d = S_IDLE;
        if (!moveIsNop) begin
          if (anyHit) begin
            blocked_d = 1'b1;
          end else begin
            x_d = candX;
            y_d = candY;
          end
        end
      end
      S_ATTACK: begin
        if (move_tick_i) begin
          if (tickCnt_q == TICK_LAST) begin
            attack_d = 1'b0;
            state_d  = S_IDLE;
          end else begin
            tickCnt_d = tickCnt_q + TICK_ONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM and position registers; reset overrides any move or attack in flight.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      x_q       <= XINIT;
      y_q       <= YINIT;
      dir_q     <= DIR_UP;
      attack_q  <= 1'b0;
      blocked_q <= 1'b0;
      tickCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      dir_q     <= dir_d;
      attack_q  <= attack_d;
      blocked_q <= blocked_d;
      tickCnt_q <= tickCnt_d;
    end
  end

  // Contact flags: touching reloads the hold counter; the flag drops the
  // cycle after the counter has run out.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NUM_BLOCKS; i++) begin
        holdCnt_q[i] <= '0;
      end
      contact_q <= '0;
    end else begin
      for (int i = 0; i < NUM_BLOCKS; i++) begin
        if (touch[i]) begin
          holdCnt_q[i] <= HOLD_LOAD;
          contact_q[i] <= 1'b1;
        end else if (holdCnt_q[i] != '0) begin
          holdCnt_q[i] <= holdCnt_q[i] - HOLD_ONE;
        end else begin
          contact_q[i] <= 1'b0;
        end
      end
    end
  end

  assign x_pos_o   = x_q;
  assign y_pos_o   = y_q;
  assign dir_o     = dir_q;
  assign attack_o  = attack_q;
  assign blocked_o = blocked_q;
  assign contact_o = contact_q;

endmodule

// File: tb/tb_hero_mover.sv
// Scoreboard bench for hero_mover: stimulus queues cycle-stamped expected
// values, and a negedge monitor compares them (and every blocked pulse)
// against the DUT outputs.
module tb_hero_mover;

  localparam int SEL_X       = 0;
  localparam int SEL_Y       = 1;
  localparam int SEL_DIR     = 2;
  localparam int SEL_ATTACK  = 3;
  localparam int SEL_BLOCKED = 4;
  localparam int SEL_CONTACT = 5;

  localparam logic [4:0] B_UP     = 5'b10000;
  localparam logic [4:0] B_LEFT   = 5'b01000;
  localparam logic [4:0] B_RIGHT  = 5'b00100;
  localparam logic [4:0] B_DOWN   = 5'b00010;
  localparam logic [4:0] B_CENTER = 5'b00001;
  localparam logic [4:0] B_NONE   = 5'b00000;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstN;
  logic        moveTick;
  logic        btnUp, btnLeft, btnRight, btnDown, btnCenter;
  logic [47:0] blockX, blockY;
  logic [3:0]  blockEn;
  logic [11:0] xPos, yPos;
  logic [1:0]  dir;
  logic        attack, blocked;
  logic [3:0]  contact;

  int   cycCnt      = 0;
  int   assertCount = 0;
  int   failCount   = 0;
  exp_t expQ[$];
  int   blockedQ[$];
  exp_t curExp;
  int   expBlkCyc;

  hero_mover dut (
    .clk_i      (clk),
    .rst_n_i    (rstN),
    .move_tick_i(moveTick),
    .up_i       (btnUp),
    .left_i     (btnLeft),
    .right_i    (btnRight),
    .down_i     (btnDown),
    .center_i   (btnCenter),
    .block_x_i  (blockX),
    .block_y_i  (blockY),
    .block_en_i (blockEn),
    .x_pos_o    (xPos),
    .y_pos_o    (yPos),
    .dir_o      (dir),
    .attack_o   (attack),
    .blocked_o  (blocked),
    .contact_o  (contact)
  );

  // Free-running clock and cycle stamp used by both stimulus and monitor.
  always #5 clk = ~clk;
  always @(posedge clk) cycCnt <= cycCnt + 1;

  function automatic string selName(input int sel);
    case (sel)
      SEL_X:       return "x_pos";
      SEL_Y:       return "y_pos";
      SEL_DIR:     return "dir";
      SEL_ATTACK:  return "attack";
      SEL_BLOCKED: return "blocked";
      default:     return "contact";
    endcase
  endfunction

  function automatic logic [31:0] readSel(input int sel);
    case (sel)
      SEL_X:       return 32'(xPos);
      SEL_Y:       return 32'(yPos);
      SEL_DIR:     return 32'(dir);
      SEL_ATTACK:  return 32'(attack);
      SEL_BLOCKED: return 32'(blocked);
      default:     return 32'(contact);
    endcase
  endfunction

  task automatic checkOutput(input string name, input int cyc, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s at cycle %0d: actual %0d, required %0d", name, cyc, actual, expected);
    end
  endtask

  task automatic expectAt(input int cyc, input int sel, input logic [31:0] val);
    exp_t e;
    int   idx;
    e.cyc = cyc;
    e.sel = sel;
    e.val = val;
    idx = expQ.size();
    while (idx > 0 && expQ[idx-1].cyc > cyc) idx--;
    expQ.insert(idx, e);
  endtask

  task automatic expectReset(input int cyc);
    expectAt(cyc, SEL_X, 512);
    expectAt(cyc, SEL_Y, 300);
    expectAt(cyc, SEL_DIR, 0);
    expectAt(cyc, SEL_ATTACK, 0);
    expectAt(cyc, SEL_BLOCKED, 0);
    expectAt(cyc, SEL_CONTACT, 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One paced move: buttons set, a single-cycle tick, then the MOVE cycle.
  task automatic applyStimulus(input logic [4:0] b);
    {btnUp, btnLeft, btnRight, btnDown, btnCenter} = b;
    moveTick = 1'b1;
    step();
    moveTick = 1'b0;
    step();
  endtask

  // Monitor: pop every expectation due this cycle, and match each blocked pulse.
  always @(negedge clk) begin
    while (expQ.size() > 0 && expQ[0].cyc <= cycCnt) begin
      curExp = expQ.pop_front();
      if (curExp.cyc < cycCnt)
        checkOutput("stale_expectation", cycCnt, 32'(curExp.cyc), 32'(cycCnt));
      else
        checkOutput(selName(curExp.sel), cycCnt, readSel(curExp.sel), curExp.val);
    end
    if (blocked === 1'b1) begin
      if (blockedQ.size() > 0) begin
        expBlkCyc = blockedQ.pop_front();
        checkOutput("blocked_pulse_cycle", cycCnt, 32'(cycCnt), 32'(expBlkCyc));
      end else begin
        checkOutput("blocked_unexpected", cycCnt, 32'(blocked), 32'd0);
      end
    end
  end

  initial begin
    rstN     = 1'b0;
    moveTick = 1'b0;
    {btnUp, btnLeft, btnRight, btnDown, btnCenter} = B_NONE;
    blockX   = '0;
    blockY   = '0;
    blockEn  = '0;

    $display("[TB] reset");
    step();
    step();
    expectReset(cycCnt);
    rstN = 1'b1;

    $display("[TB] free move right");
    for (int k = 1; k <= 10; k++) begin
      expectAt(cycCnt + 1, SEL_X, 32'(511 + k));
      expectAt(cycCnt + 2, SEL_X, 32'(512 + k));
      applyStimulus(B_RIGHT);
    end
    expectAt(cycCnt, SEL_DIR, 2);
    expectAt(cycCnt, SEL_Y, 300);

    $display("[TB] arena bounds");
    for (int k = 0; k < 459; k++) applyStimulus(B_LEFT);
    expectAt(cycCnt, SEL_X, 63);
    for (int k = 0; k < 3; k++) begin
      expectAt(cycCnt + 2, SEL_X, 62);
      applyStimulus(B_LEFT);
    end
    for (int k = 0; k < 407; k++) applyStimulus(B_DOWN);
    expectAt(cycCnt, SEL_Y, 707);
    for (int k = 0; k < 3; k++) begin
      expectAt(cycCnt + 2, SEL_Y, 708);
      applyStimulus(B_DOWN);
    end
    expectAt(cycCnt, SEL_DIR, 3);
    expectAt(cycCnt, SEL_BLOCKED, 0);

    $display("[TB] obstacle");
    {btnUp, btnLeft, btnRight, btnDown, btnCenter} = B_NONE;
    blockX[11:0]  = 12'd580;
    blockY[11:0]  = 12'd300;
    blockX[23:12] = 12'd540;
    blockY[23:12] = 12'd300;
    blockEn       = 4'b0001;
    rstN = 1'b0;
    step();
    expectReset(cycCnt);
    rstN = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      expectAt(cycCnt + 2, SEL_X, 32'(512 + k));
      applyStimulus(B_RIGHT);
    end
    expectAt(cycCnt + 2, SEL_X, 520);
    expectAt(cycCnt + 2, SEL_CONTACT, 0);
    expectAt(cycCnt + 3, SEL_CONTACT, 1);
    applyStimulus(B_RIGHT);
    expectAt(cycCnt + 2, SEL_X, 520);
    expectAt(cycCnt + 2, SEL_BLOCKED, 1);
    expectAt(cycCnt + 3, SEL_BLOCKED, 0);
    blockedQ.push_back(cycCnt + 2);
    applyStimulus(B_RIGHT);
    expectAt(cycCnt + 1, SEL_DIR, 0);
    expectAt(cycCnt + 2, SEL_Y, 299);
    expectAt(cycCnt + 2, SEL_X, 520);
    expectAt(cycCnt + 2, SEL_CONTACT, 1);
    applyStimulus(B_UP);
    {btnUp, btnLeft, btnRight, btnDown, btnCenter} = B_NONE;
    blockEn = 4'b0000;
    expectAt(cycCnt + 199, SEL_CONTACT, 1);
    expectAt(cycCnt + 200, SEL_CONTACT, 0);
    repeat (201) step();

    $display("[TB] attack window");
    expectAt(cycCnt + 1, SEL_ATTACK, 1);
    expectAt(cycCnt + 1, SEL_DIR, 0);
    applyStimulus(B_CENTER);
    for (int k = 1; k <= 8; k++) begin
      expectAt(cycCnt, SEL_ATTACK, 1);
      expectAt(cycCnt + 1, SEL_ATTACK, (k < 8) ? 32'd1 : 32'd0);
      expectAt(cycCnt + 1, SEL_X, 520);
      expectAt(cycCnt + 1, SEL_Y, 299);
      applyStimulus(B_UP);
    end
    expectAt(cycCnt + 2, SEL_Y, 298);
    applyStimulus(B_UP);

    $display("[TB] reset during move");
    {btnUp, btnLeft, btnRight, btnDown, btnCenter} = B_LEFT;
    moveTick = 1'b1;
    expectAt(cycCnt + 1, SEL_DIR, 1);
    expectAt(cycCnt + 1, SEL_X, 520);
    expectReset(cycCnt + 2);
    step();
    moveTick = 1'b0;
    rstN     = 1'b0;
    step();
    rstN = 1'b1;
    {btnUp, btnLeft, btnRight, btnDown, btnCenter} = B_NONE;

    $display("[TB] reset during attack with held contact");
    blockX[11:0] = 12'd572;
    blockY[11:0] = 12'd300;
    blockEn      = 4'b0001;
    expectAt(cycCnt + 1, SEL_CONTACT, 1);
    step();
    expectAt(cycCnt + 1, SEL_ATTACK, 1);
    applyStimulus(B_CENTER);
    {btnUp, btnLeft, btnRight, btnDown, btnCenter} = B_NONE;
    rstN    = 1'b0;
    blockEn = 4'b0000;
    expectReset(cycCnt + 1);
    step();
    rstN = 1'b1;
    expectAt(cycCnt + 2, SEL_Y, 299);
    expectAt(cycCnt + 2, SEL_ATTACK, 0);
    applyStimulus(B_UP);

    for (int i = 0; i < 20 && expQ.size() > 0; i++) step();
    step();
    checkOutput("scoreboard_drain", cycCnt, 32'(expQ.size()), 32'd0);
    checkOutput("blocked_pending", cycCnt, 32'(blockedQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
